// File: rtl/regfile_wb_sink.sv
// -----------------------------------------------------------------------------
// regfile_wb_sink
//   Register-file end of the write-back interface. WB commits one result per
//   cycle into a 32x32 GPR array; ID gets two combinational read ports. A
//   per-register pending-write scoreboard is kept alongside: ID reserves its
//   destination when it issues, WB releases it when it commits, and id_stall
//   holds ID while a source operand still has a write in flight. $0 reads 0,
//   is never written, never busy and never counted.
//
// Parameters
//   NREGS    number of architectural registers (address width fixed at 5)
//   DW       data width
//   MAXPEND  max in-flight writes per register; counter is clog2(MAXPEND+1) bits
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_regwrite/wb_addr/wb_data  WB commit strobe, destination, result
//   id_rs_addr/id_rt_addr      read port A/B addresses
//   id_rs_used/id_rt_used      ID instruction actually reads rs/rt
//   id_resv_valid/id_resv_addr ID instruction writes a register (reserve)
//   rs_data/rt_data            read port A/B data
//   id_stall                   hold ID / insert bubble
//   sb_err                     sticky scoreboard error (overflow / underflow)
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a read of the register being committed
//                      this cycle returns wb_data, and the last in-flight write
//                      of a register stops stalling in its commit cycle.
// -----------------------------------------------------------------------------
module regfile_wb_sink #(
    parameter int NREGS   = 32,
    parameter int DW      = 32,
    parameter int MAXPEND = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_regwrite,
    input  logic [4:0]           wb_addr,
    input  logic signed [DW-1:0] wb_data,
    input  logic [4:0]           id_rs_addr,
    input  logic [4:0]           id_rt_addr,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 id_resv_valid,
    input  logic [4:0]           id_resv_addr,
    output logic [DW-1:0]        rs_data,
    output logic [DW-1:0]        rt_data,
    output logic                 id_stall,
    output logic                 sb_err
);

    localparam int PW = $clog2(MAXPEND + 1);
    typedef logic [PW-1:0] cnt_t;

    logic [DW-1:0]    gpr      [NREGS];
    cnt_t             pend     [NREGS];
    cnt_t             pend_nxt [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_eff;
    logic [NREGS-1:0] rel_vec;
    logic [NREGS-1:0] resv_vec;
    logic [NREGS-1:0] err_vec;
    logic             resv_acc;
    logic             commit;

    // Saturating pending-counter update. Returns {error, next_count}.
    // A release against an empty counter is an error and leaves it at 0,
    // even if a reserve to the same register arrives in that cycle.
    function automatic logic [PW:0] pend_update(input cnt_t cur,
                                                input logic inc,
                                                input logic dec);
        logic err;
        cnt_t nxt;
        err = 1'b0;
        nxt = cur;
        if (dec && (cur == '0)) begin
            err = 1'b1;
        end else if (inc && !dec) begin
            if (cur == cnt_t'(MAXPEND)) err = 1'b1;
            else                        nxt = cur + cnt_t'(1);
        end else if (dec && !inc) begin
            nxt = cur - cnt_t'(1);
        end
        return {err, nxt};
    endfunction

    assign commit = wb_regwrite && (wb_addr != 5'd0);

    // Busy / release decode per register.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rel_vec[r] = commit && (wb_addr == 5'(r));
            busy[r]    = (r != 0) && (pend[r] != '0);
`ifdef REGFILE_BYPASS_EN
            // The last outstanding write is being committed and forwarded.
            busy_eff[r] = busy[r] && !(rel_vec[r] && (pend[r] == cnt_t'(1)));
`else
            busy_eff[r] = busy[r];
`endif
        end
    end

    // Stall uses pre-reservation state, so an instruction whose source is
    // also its own destination does not stall on itself.
    assign id_stall = (id_rs_used && busy_eff[id_rs_addr]) ||
                      (id_rt_used && busy_eff[id_rt_addr]);

    assign resv_acc = id_resv_valid && !id_stall && (id_resv_addr != 5'd0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            resv_vec[r] = resv_acc && (id_resv_addr == 5'(r));
            {err_vec[r], pend_nxt[r]} = pend_update(pend[r], resv_vec[r], rel_vec[r]);
        end
    end

    // Read ports.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (id_rs_addr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
            if (rst_n && commit && (wb_addr == id_rs_addr)) rs_data = wb_data;
            else                                            rs_data = gpr[id_rs_addr];
`else
            rs_data = gpr[id_rs_addr];
`endif
        end
        if (id_rt_addr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
            if (rst_n && commit && (wb_addr == id_rt_addr)) rt_data = wb_data;
            else                                            rt_data = gpr[id_rt_addr];
`else
            rt_data = gpr[id_rt_addr];
`endif
        end
    end

    // GPR array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) gpr[r] <= '0;
        end else if (commit) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Scoreboard counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend[r] <= pend_nxt[r];
            if (|err_vec) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sink.sv
module tb_regfile_wb_sink;

    localparam int DW      = 32;
    localparam int NREGS   = 32;
    localparam int MAXPEND = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wb_regwrite;
    logic [4:0]           wb_addr;
    logic signed [DW-1:0] wb_data;
    logic [4:0]           id_rs_addr;
    logic [4:0]           id_rt_addr;
    logic                 id_rs_used;
    logic                 id_rt_used;
    logic                 id_resv_valid;
    logic [4:0]           id_resv_addr;
    logic [DW-1:0]        rs_data;
    logic [DW-1:0]        rt_data;
    logic                 id_stall;
    logic                 sb_err;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, number of writes in flight per
    // register, and the sticky error flag.
    logic [31:0] m_gpr  [NREGS];
    int          m_pend [NREGS];
    bit          m_err;

    regfile_wb_sink #(.NREGS(NREGS), .DW(DW), .MAXPEND(MAXPEND)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_regwrite  (wb_regwrite),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_resv_valid(id_resv_valid),
        .id_resv_addr (id_resv_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .id_stall     (id_stall),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit m_busy(int r);
        if (r == 0 || m_pend[r] == 0) return 1'b0;
        if (BYP && wb_regwrite && int'(wb_addr) == r && m_pend[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return (id_rs_used && m_busy(int'(id_rs_addr))) ||
               (id_rt_used && m_busy(int'(id_rt_addr)));
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'd0;
        if (BYP && wb_regwrite && int'(wb_addr) == a) return wb_data;
        return m_gpr[a];
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_gpr[r]  = 32'd0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic set_idle();
        wb_regwrite   = 1'b0;
        wb_addr       = 5'd0;
        wb_data       = '0;
        id_rs_addr    = 5'd0;
        id_rt_addr    = 5'd0;
        id_rs_used    = 1'b0;
        id_rt_used    = 1'b0;
        id_resv_valid = 1'b0;
        id_resv_addr  = 5'd0;
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        bit acc;
        int ra;
        int wa;
        acc = id_resv_valid && !m_stall() && id_resv_addr != 5'd0;
        ra  = int'(id_resv_addr);
        wa  = int'(wb_addr);
        if (rst_n) begin
            if (wb_regwrite && wa != 0) begin
                m_gpr[wa] = wb_data;
                if (m_pend[wa] == 0)        m_err = 1'b1;
                else if (!(acc && ra == wa)) m_pend[wa] = m_pend[wa] - 1;
            end
            if (acc && !(wb_regwrite && wa == ra)) begin
                if (m_pend[ra] == MAXPEND) m_err = 1'b1;
                else                       m_pend[ra] = m_pend[ra] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] pre;
        // Power-on reset
        set_idle();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        id_rs_addr = 5'd9; id_rt_addr = 5'd17; id_rs_used = 1'b1; id_rt_used = 1'b1;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL por_rs_data got=%h exp=0", rs_data); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL por_stall got=%b exp=0", id_stall); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL por_sb_err got=%b exp=0", sb_err); end
        set_idle();
        rst_n = 1'b1;
        tick();
        // Give r6 a value, then leave r5 with two writes in flight
        id_resv_valid = 1'b1; id_resv_addr = 5'd6;
        tick();
        set_idle();
        wb_regwrite = 1'b1; wb_addr = 5'd6; wb_data = 32'hA5A5_0006;
        tick();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd5;
        tick();
        tick();
        set_idle();
        id_rs_used = 1'b1; id_rs_addr = 5'd6;
        #1;
        pre = rs_data;
        checks++; if (pre !== 32'hA5A5_0006) begin errors++; $display("FAIL pre_reset_r6 got=%h exp=a5a50006", pre); end
        id_rs_addr = 5'd5;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall_r5 got=%b exp=1", id_stall); end
        // Asynchronous reset mid-run
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_r5 got=%b exp=0", id_stall); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
        for (int a = 0; a < NREGS; a++) begin
            id_rs_addr = 5'(a);
            #1;
            checks++;
            if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, rs_data); end
        end
        set_idle();
        rst_n = 1'b1;
        tick();
        id_rs_used = 1'b1; id_rs_addr = 5'd5;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall_r5 got=%b exp=0", id_stall); end
        set_idle();
    endtask

    task automatic test_write_read();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd7;
        tick();
        set_idle();
        wb_regwrite = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        id_rs_addr = 5'd7;
        #1;
        checks++;
        if (rs_data !== (BYP ? 32'hDEAD_BEEF : 32'd0))
            begin errors++; $display("FAIL wr_same_cycle got=%h exp=%h", rs_data, BYP ? 32'hDEAD_BEEF : 32'd0); end
        tick();
        set_idle();
        id_rs_addr = 5'd7; id_rt_addr = 5'd7;
        #1;
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_read_rs got=%h exp=deadbeef", rs_data); end
        checks++; if (rt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_read_rt got=%h exp=deadbeef", rt_data); end
        wb_regwrite = 1'b1; wb_addr = 5'd0; wb_data = 32'd1;
        id_rs_addr = 5'd0;
        tick();
        set_idle();
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL wr_r0 got=%h exp=0", rs_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL wr_sb_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_raw_stall();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd3;
        tick();
        set_idle();
        id_rs_used = 1'b1; id_rs_addr = 5'd3;
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c%0d got=%b exp=1", c, id_stall); end
            tick();
        end
        wb_regwrite = 1'b1; wb_addr = 5'd3; wb_data = 32'h0BAD_F00D;
        #1;
        checks++; if (id_stall !== !BYP) begin errors++; $display("FAIL raw_stall_c3 got=%b exp=%b", id_stall, !BYP); end
        if (BYP) begin
            checks++; if (rs_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL raw_bypass got=%h exp=0badf00d", rs_data); end
        end
        tick();
        wb_regwrite = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_c4 got=%b exp=0", id_stall); end
        checks++; if (rs_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL raw_read_c4 got=%h exp=0badf00d", rs_data); end
        set_idle();
    endtask

    task automatic test_simultaneous();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd4;
        tick();
        wb_regwrite = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444_0001;
        tick();
        set_idle();
        id_rs_used = 1'b1; id_rs_addr = 5'd4;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL simul_stall got=%b exp=1", id_stall); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL simul_sb_err got=%b exp=0", sb_err); end
        wb_regwrite = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444_0002;
        tick();
        wb_regwrite = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", id_stall); end
        set_idle();
    endtask

    task automatic test_errors();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd9;
        tick(); tick(); tick();
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", sb_err); end
        tick();
        set_idle();
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL ovf_sb_err got=%b exp=1", sb_err); end
        // Counter must hold at 3: two releases still leave it busy, a third clears it
        id_rs_used = 1'b1; id_rs_addr = 5'd9;
        for (int k = 0; k < 3; k++) begin
            wb_regwrite = 1'b1; wb_addr = 5'd9; wb_data = 32'(k);
            tick();
            wb_regwrite = 1'b0;
            #1;
            checks++;
            if (id_stall !== (k < 2)) begin errors++; $display("FAIL ovf_drain_%0d got=%b exp=%b", k, id_stall, k < 2); end
        end
        set_idle();
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL udf_reset got=%b exp=0", sb_err); end
        rst_n = 1'b1;
        tick();
        wb_regwrite = 1'b1; wb_addr = 5'd10; wb_data = 32'h1234_5678;
        tick();
        set_idle();
        id_rs_addr = 5'd10;
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL udf_sb_err got=%b exp=1", sb_err); end
        checks++; if (rs_data !== 32'h1234_5678) begin errors++; $display("FAIL udf_data got=%h exp=12345678", rs_data); end
        rst_n = 1'b0;
        m_reset();
        #1;
        rst_n = 1'b1;
        set_idle();
        tick();
    endtask

    task automatic test_stalled_reserve();
        set_idle();
        id_resv_valid = 1'b1; id_resv_addr = 5'd11;
        tick();
        id_rs_used = 1'b1; id_rs_addr = 5'd11;
        id_resv_valid = 1'b1; id_resv_addr = 5'd12;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL stres_stall got=%b exp=1", id_stall); end
        tick(); tick();
        set_idle();
        id_rs_used = 1'b1; id_rs_addr = 5'd12;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL stres_r12_free got=%b exp=0", id_stall); end
        // Self-dependency: reading and reserving r12 together does not stall
        id_resv_valid = 1'b1; id_resv_addr = 5'd12;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL self_dep got=%b exp=0", id_stall); end
        tick();
        id_resv_valid = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL self_dep_after got=%b exp=1", id_stall); end
        set_idle();
    endtask

    task automatic test_random();
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rnd_reset got=%b exp=0", sb_err); end
                rst_n = 1'b1;
            end
            id_rs_addr    = 5'($urandom_range(0, 7));
            id_rt_addr    = 5'($urandom_range(0, 7));
            id_rs_used    = 1'($urandom_range(0, 1));
            id_rt_used    = 1'($urandom_range(0, 1));
            id_resv_valid = ($urandom_range(0, 2) == 0);
            id_resv_addr  = 5'($urandom_range(0, 7));
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            wb_regwrite   = (m_pend[wb_addr] != 0) ? ($urandom_range(0, 2) != 0)
                                                   : ($urandom_range(0, 15) == 0);
            #2;
            exp_rs = m_read(int'(id_rs_addr));
            exp_rt = m_read(int'(id_rt_addr));
            checks++; if (rs_data !== exp_rs) begin errors++; $display("FAIL rnd_rs i=%0d a=%0d got=%h exp=%h", i, id_rs_addr, rs_data, exp_rs); end
            checks++; if (rt_data !== exp_rt) begin errors++; $display("FAIL rnd_rt i=%0d a=%0d got=%h exp=%h", i, id_rt_addr, rt_data, exp_rt); end
            checks++; if (id_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, id_stall, m_stall()); end
            checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_sb_err i=%0d got=%b exp=%b", i, sb_err, m_err); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_raw_stall();
        test_simultaneous();
        test_errors();
        test_stalled_reserve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
